branch_loop_profiler: RTL and testbench
=======================================

Name: branch_loop_profiler

Overview:
- Receiving end of the branch unit's profiler interface.
- Watches every issued branch or jump and filters for taken backward transfers, which are loop back-edges.
- Keeps a small fully associative table of hot loops, holding back-edge PC, loop start address and a saturating execution count.
- Software or the accelerator-selection logic reads the table through an indexed read port and can clear it with a sequenced sweep.

Parameters:
- NUM_ENTRIES, 8: number of table entries; power of two, 2..32.
- COUNT_W, 16: width of each saturating hit counter.
- OFFSET_W, 21: width of the signed branch PC offset.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  profiling enabled; events are ignored while low.
- branch_instr_issue  input  1  branch/jump issued this cycle.
- branch_instr_pc  input  32  PC of the issued branch.
- branch_pc_offset  input  OFFSET_W  signed offset of the branch.
- branch_taken  input  1  branch/jump resolved taken.
- clear_req  input  1  one-cycle pulse; start a table clear.
- clear_busy  output  1  clear sweep in progress.
- rd_req  input  1  read request.
- rd_index  input  $clog2(NUM_ENTRIES)  entry to read.
- rd_ready  output  1  read request is accepted this cycle.
- rd_valid  output  1  read data valid.
- rd_entry_valid  output  1  the entry read is occupied.
- rd_branch_pc  output  32  back-edge PC of the entry.
- rd_target_pc  output  32  loop start address of the entry.
- rd_count  output  COUNT_W  hit count of the entry.
- dropped_events  output  16  saturating count of qualifying events lost.

Behaviour:
- Reset (rst low, asynchronous):
  - All entry valid bits, counts, dropped_events, rd_valid and clear_busy go to 0.
  - The FSM goes to IDLE.
  - Table PC fields are don't-care.
- Qualification: an event qualifies when branch_instr_issue & branch_taken & branch_pc_offset[OFFSET_W-1] & enable, in the same cycle.
- Stage 1: a qualifying event is registered as ev_valid, ev_pc and ev_target. ev_target = branch_instr_pc + sign-extended offset, computed mod 2^32.
- Stage 2 (next cycle): CAM compare of ev_pc against all valid entries. The table is written at the end of this cycle, so issue-to-visible latency is 2 cycles.
  - Hit: count increments and saturates at 2^COUNT_W-1; it never wraps.
  - Miss with a free entry: the lowest-index invalid entry is written with valid=1, count=1 and the PCs.
  - Miss with a full table: the victim is the entry with the minimum count, lowest index on ties. It is overwritten with count=1.
- Throughput: one event per cycle. Back-to-back events with the same PC each count, because the stage-2 write completes before the next lookup.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clear_req; clear_busy rises the next cycle.
  - CLEAR invalidates one entry per cycle, index 0..NUM_ENTRIES-1, then returns to IDLE. clear_busy is high for exactly NUM_ENTRIES cycles.
  - clear_req during CLEAR is ignored.
  - An in-flight stage-2 event in the cycle clear_req is accepted is still written, and may be erased by the sweep.
- Dropped events: qualifying events arriving while clear_busy is high are dropped. Each drop increments dropped_events, which saturates at 0xFFFF. dropped_events is reset only by rst, not by clear.
- Read port:
  - rd_ready = ~clear_busy.
  - When rd_req & rd_ready, rd_valid is asserted the next cycle for exactly one cycle, carrying the entry as of the start of the request cycle.
  - A stage-2 write to the same entry in the request cycle is not reflected.
  - rd_valid is 0 otherwise. Outputs other than rd_valid hold their last value.
- enable deasserted mid-flight: an event already in stage 1 still completes.

Test Plan:
- Reset, then issue 5 events with pc=0x1000, offset=-16, taken -> after 2 cycles a read of index 0 gives valid=1, branch_pc=0x1000, target=0x0FF0, count=5.
- Issue a forward branch (offset=+8) and a backward not-taken branch at pc=0x2000 -> no entry is allocated and all reads return entry_valid=0.
- Fill 8 entries with distinct PCs and counts 1..8 (entry 0 has count 1), then send a new pc=0x9000 -> entry 0 is replaced with pc=0x9000, count=1 and the other entries are unchanged.
- With COUNT_W=4, issue 20 hits on one PC -> count reads 15.
- Pulse clear_req with a full table, then issue 3 qualifying events while busy -> clear_busy is high for 8 cycles, rd_ready=0 during the sweep, afterwards all entries read invalid and dropped_events=3.
- Assert rst low asynchronously mid-clear with events in flight -> clear_busy, rd_valid and dropped_events go to 0 immediately and all entries are invalid after reset.

Source files
------------

// File: rtl/branch_loop_profiler.sv
// Loop back-edge profiler: filters taken backward branches and keeps a small
// fully associative table of hot loops with saturating hit counts.
module branch_loop_profiler #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned OFFSET_W    = 21
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           branch_instr_issue,
  input  logic [31:0]                    branch_instr_pc,
  input  logic [OFFSET_W-1:0]            branch_pc_offset,
  input  logic                           branch_taken,
  input  logic                           clear_req,
  output logic                           clear_busy,
  input  logic                           rd_req,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_index,
  output logic                           rd_ready,
  output logic                           rd_valid,
  output logic                           rd_entry_valid,
  output logic [31:0]                    rd_branch_pc,
  output logic [31:0]                    rd_target_pc,
  output logic [COUNT_W-1:0]             rd_count,
  output logic [15:0]                    dropped_events
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t               r_state, w_state_nxt;
  logic                 w_clear_busy;
  logic [IDX_W-1:0]     r_clr_idx;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [COUNT_W-1:0]     r_cnt [NUM_ENTRIES];
  logic [31:0]            r_pc  [NUM_ENTRIES];
  logic [31:0]            r_tgt [NUM_ENTRIES];

  logic                 w_qual;
  logic [31:0]          w_off_ext;
  logic                 r_ev_valid;
  logic [31:0]          r_ev_pc;
  logic [31:0]          r_ev_target;

  logic                 w_hit_any;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_free_any;
  logic [IDX_W-1:0]     w_free_idx;
  logic [COUNT_W-1:0]   w_min_cnt;
  logic [IDX_W-1:0]     w_victim_idx;
  logic [IDX_W-1:0]     w_alloc_idx;

  logic [15:0]          r_dropped;
  logic                 r_rd_valid;
  logic                 r_rd_entry_valid;
  logic [31:0]          r_rd_branch_pc;
  logic [31:0]          r_rd_target_pc;
  logic [COUNT_W-1:0]   r_rd_count;

  assign w_qual    = branch_instr_issue & branch_taken & branch_pc_offset[OFFSET_W-1] & enable;
  assign w_off_ext = 32'($signed(branch_pc_offset));

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_idx == IDX_W'(NUM_ENTRIES - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_clear_busy = (r_state == S_CLEAR);
  end

  // Stage-2 lookup: first hit, first free slot, and min-count victim (lowest index on ties)
  always_comb begin
    w_hit_any    = 1'b0;
    w_hit_idx    = '0;
    w_free_any   = 1'b0;
    w_free_idx   = '0;
    w_min_cnt    = r_cnt[0];
    w_victim_idx = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!w_hit_any && r_valid[i] && (r_pc[i] == r_ev_pc)) begin
        w_hit_any = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!w_free_any && !r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_cnt[i] < w_min_cnt) begin
        w_min_cnt    = r_cnt[i];
        w_victim_idx = IDX_W'(i);
      end
    end
    w_alloc_idx = w_free_any ? w_free_idx : w_victim_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_ev_valid <= 1'b0;
      r_dropped  <= '0;
      r_rd_valid <= 1'b0;
      r_clr_idx  <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_cnt[i] <= '0;
    end else begin
      r_ev_valid <= w_qual & ~w_clear_busy;
      r_rd_valid <= rd_req & ~w_clear_busy;
      if (w_qual && w_clear_busy && (r_dropped != '1)) r_dropped <= r_dropped + 16'd1;
      r_clr_idx <= w_clear_busy ? r_clr_idx + IDX_W'(1) : '0;
      if (r_ev_valid) begin
        if (w_hit_any) begin
          if (r_cnt[w_hit_idx] != '1) r_cnt[w_hit_idx] <= r_cnt[w_hit_idx] + COUNT_W'(1);
        end else begin
          r_valid[w_alloc_idx] <= 1'b1;
          r_cnt[w_alloc_idx]   <= COUNT_W'(1);
        end
      end
      // The sweep invalidation is placed last so it wins over a same-entry stage-2 allocation
      if (w_clear_busy) r_valid[r_clr_idx] <= 1'b0;
    end
  end

  // Data-only registers; their contents are qualified by the valid bits above
  always_ff @(posedge clk) begin
    if (w_qual) begin
      r_ev_pc     <= branch_instr_pc;
      r_ev_target <= branch_instr_pc + w_off_ext;
    end
    if (r_ev_valid && !w_hit_any) begin
      r_pc[w_alloc_idx]  <= r_ev_pc;
      r_tgt[w_alloc_idx] <= r_ev_target;
    end
    if (rd_req && !w_clear_busy) begin
      r_rd_entry_valid <= r_valid[rd_index];
      r_rd_branch_pc   <= r_pc[rd_index];
      r_rd_target_pc   <= r_tgt[rd_index];
      r_rd_count       <= r_cnt[rd_index];
    end
  end

  assign clear_busy     = w_clear_busy;
  assign rd_ready       = ~w_clear_busy;
  assign rd_valid       = r_rd_valid;
  assign rd_entry_valid = r_rd_entry_valid;
  assign rd_branch_pc   = r_rd_branch_pc;
  assign rd_target_pc   = r_rd_target_pc;
  assign rd_count       = r_rd_count;
  assign dropped_events = r_dropped;

endmodule

// File: tb/tb_branch_loop_profiler.sv
// Directed bench for branch_loop_profiler; a COUNT_W=4 instance shares the stimulus.
module tb_branch_loop_profiler;

  localparam logic [20:0] OFF_M16 = 21'h1FFFF0;
  localparam logic [20:0] OFF_P8  = 21'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        branch_instr_issue = 1'b0;
  logic [31:0] branch_instr_pc = '0;
  logic [20:0] branch_pc_offset = '0;
  logic        branch_taken = 1'b0;
  logic        clear_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_index = '0;

  logic        clear_busy, rd_ready, rd_valid, rd_entry_valid;
  logic [31:0] rd_branch_pc, rd_target_pc;
  logic [15:0] rd_count, dropped_events;

  logic        d4_clear_busy, d4_rd_ready, d4_rd_valid, d4_rd_entry_valid;
  logic [31:0] d4_rd_branch_pc, d4_rd_target_pc;
  logic [3:0]  d4_rd_count;
  logic [15:0] d4_dropped_events;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_loop_profiler #(.NUM_ENTRIES(8), .COUNT_W(16), .OFFSET_W(21)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .branch_instr_issue(branch_instr_issue), .branch_instr_pc(branch_instr_pc),
    .branch_pc_offset(branch_pc_offset), .branch_taken(branch_taken),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .rd_req(rd_req), .rd_index(rd_index), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_entry_valid(rd_entry_valid), .rd_branch_pc(rd_branch_pc),
    .rd_target_pc(rd_target_pc), .rd_count(rd_count), .dropped_events(dropped_events)
  );

  branch_loop_profiler #(.NUM_ENTRIES(8), .COUNT_W(4), .OFFSET_W(21)) dut4 (
    .clk(clk), .rst(rst), .enable(enable),
    .branch_instr_issue(branch_instr_issue), .branch_instr_pc(branch_instr_pc),
    .branch_pc_offset(branch_pc_offset), .branch_taken(branch_taken),
    .clear_req(clear_req), .clear_busy(d4_clear_busy),
    .rd_req(rd_req), .rd_index(rd_index), .rd_ready(d4_rd_ready), .rd_valid(d4_rd_valid),
    .rd_entry_valid(d4_rd_entry_valid), .rd_branch_pc(d4_rd_branch_pc),
    .rd_target_pc(d4_rd_target_pc), .rd_count(d4_rd_count), .dropped_events(d4_dropped_events)
  );

  task automatic quiet();
    branch_instr_issue = 1'b0;
    branch_taken       = 1'b0;
    clear_req          = 1'b0;
    rd_req             = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    enable = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One issued branch held for one cycle
  task automatic ev(input logic [31:0] pc, input logic [20:0] off, input logic taken);
    branch_instr_issue = 1'b1;
    branch_instr_pc    = pc;
    branch_pc_offset   = off;
    branch_taken       = taken;
    rd_req             = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    quiet();
    repeat (n) @(negedge clk);
  endtask

  // Read request for one cycle; returns at the negedge where rd_valid should show
  task automatic rd(input logic [2:0] idx);
    branch_instr_issue = 1'b0;
    rd_req   = 1'b1;
    rd_index = idx;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", clear_busy); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_vec++; if (dropped_events !== 16'd0) begin n_err++; $display("FAIL reset_dropped: got %0d expected 0", dropped_events); end
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL reset_rd_ready: got %b expected 1", rd_ready); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_hits();
    do_reset();
    for (int i = 0; i < 5; i++) ev(32'h1000, OFF_M16, 1'b1);
    idle(2);
    rd(3'd0);
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid); end
    n_vec++; if (rd_entry_valid !== 1'b1) begin n_err++; $display("FAIL basic_entry_valid: got %b expected 1", rd_entry_valid); end
    n_vec++; if (rd_branch_pc !== 32'h1000) begin n_err++; $display("FAIL basic_pc: got %h expected 00001000", rd_branch_pc); end
    n_vec++; if (rd_target_pc !== 32'h0FF0) begin n_err++; $display("FAIL basic_target: got %h expected 00000ff0", rd_target_pc); end
    n_vec++; if (rd_count !== 16'd5) begin n_err++; $display("FAIL basic_count: got %0d expected 5", rd_count); end
    @(negedge clk);
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_rd_pulse: got %b expected 0", rd_valid); end
    // Latency: a read launched one cycle after issue still sees the old table
    ev(32'h1100, OFF_M16, 1'b1);
    rd(3'd1);
    n_vec++; if (rd_entry_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got %b expected 0", rd_entry_valid); end
    rd(3'd1);
    n_vec++; if (rd_entry_valid !== 1'b1 || rd_branch_pc !== 32'h1100) begin
      n_err++; $display("FAIL latency_visible: got v=%b pc=%h expected v=1 pc=00001100", rd_entry_valid, rd_branch_pc);
    end
  endtask

  task automatic test_filter();
    do_reset();
    ev(32'h2000, OFF_P8, 1'b1);
    ev(32'h2000, OFF_M16, 1'b0);
    enable = 1'b0;
    ev(32'h2100, OFF_M16, 1'b1);
    enable = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      n_vec++; if (rd_valid !== 1'b1 || rd_entry_valid !== 1'b0) begin
        n_err++; $display("FAIL filter_entry%0d: got rv=%b v=%b expected rv=1 v=0", i, rd_valid, rd_entry_valid);
      end
    end
  endtask

  task automatic test_replace();
    logic [31:0] pc;
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int j = 0; j <= k; j++) ev(32'(32'h3000 + k * 256), OFF_M16, 1'b1);
    ev(32'h9000, OFF_M16, 1'b1);
    idle(2);
    rd(3'd0);
    n_vec++; if (rd_entry_valid !== 1'b1 || rd_branch_pc !== 32'h9000 || rd_target_pc !== 32'h8FF0 || rd_count !== 16'd1) begin
      n_err++; $display("FAIL replace_victim: got v=%b pc=%h tgt=%h cnt=%0d expected v=1 pc=00009000 tgt=00008ff0 cnt=1",
                        rd_entry_valid, rd_branch_pc, rd_target_pc, rd_count);
    end
    for (int k = 1; k < 8; k++) begin
      pc = 32'(32'h3000 + k * 256);
      rd(3'(k));
      n_vec++; if (rd_entry_valid !== 1'b1 || rd_branch_pc !== pc || rd_target_pc !== pc - 32'd16 || rd_count !== 16'(k + 1)) begin
        n_err++; $display("FAIL replace_keep%0d: got v=%b pc=%h tgt=%h cnt=%0d expected v=1 pc=%h tgt=%h cnt=%0d",
                          k, rd_entry_valid, rd_branch_pc, rd_target_pc, rd_count, pc, pc - 32'd16, k + 1);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) ev(32'h4000, OFF_M16, 1'b1);
    idle(2);
    rd(3'd0);
    n_vec++; if (rd_count !== 16'd20) begin n_err++; $display("FAIL sat_count16: got %0d expected 20", rd_count); end
    n_vec++; if (d4_rd_count !== 4'd15) begin n_err++; $display("FAIL sat_count4: got %0d expected 15", d4_rd_count); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int cyc;
    do_reset();
    for (int k = 0; k < 8; k++) ev(32'(32'h6000 + k * 256), OFF_M16, 1'b1);
    idle(2);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (clear_busy === 1'b1 && cyc < 30) begin
      n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL clear_rd_ready: got %b expected 0", rd_ready); end
      n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clear_rd_blocked: got %b expected 0", rd_valid); end
      busy_cnt++;
      branch_instr_issue = (busy_cnt <= 3);
      branch_instr_pc    = 32'h7000;
      branch_pc_offset   = OFF_M16;
      branch_taken       = 1'b1;
      clear_req          = (busy_cnt == 4);
      rd_req             = 1'b1;
      @(negedge clk);
      cyc++;
    end
    quiet();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clear_rd_last: got %b expected 0", rd_valid); end
    n_vec++; if (busy_cnt != 8) begin n_err++; $display("FAIL clear_busy_len: got %0d expected 8", busy_cnt); end
    idle(3);
    n_vec++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL clear_no_restart: got %b expected 0", clear_busy); end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      n_vec++; if (rd_entry_valid !== 1'b0) begin n_err++; $display("FAIL clear_entry%0d: got %b expected 0", i, rd_entry_valid); end
    end
    n_vec++; if (dropped_events !== 16'd3) begin n_err++; $display("FAIL clear_dropped: got %0d expected 3", dropped_events); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) ev(32'(32'h5000 + k * 256), OFF_M16, 1'b1);
    idle(2);
    clear_req = 1'b1;
    rd_req    = 1'b1;
    rd_index  = 3'd0;
    @(negedge clk);
    quiet();
    n_vec++; if (rd_valid !== 1'b1 || clear_busy !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got rv=%b busy=%b expected rv=1 busy=1", rd_valid, clear_busy);
    end
    ev(32'h5800, OFF_M16, 1'b1);
    ev(32'h5900, OFF_M16, 1'b1);
    n_vec++; if (dropped_events !== 16'd2) begin n_err++; $display("FAIL areset_dropped_pre: got %0d expected 2", dropped_events); end
    branch_instr_issue = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_vec++; if (clear_busy !== 1'b0 || rd_valid !== 1'b0 || dropped_events !== 16'd0) begin
      n_err++; $display("FAIL areset_immediate: got busy=%b rv=%b drop=%0d expected 0 0 0", clear_busy, rd_valid, dropped_events);
    end
    quiet();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      n_vec++; if (rd_entry_valid !== 1'b0) begin n_err++; $display("FAIL areset_entry%0d: got %b expected 0", i, rd_entry_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_hits();
    test_filter();
    test_replace();
    test_saturate();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
